// File: rtl/acc_op_sequencer.sv
// Command sequencer for the 4-bit accumulator: queues ops in a FIFO, issues them one at a
// time (with an optional accumulator clear), waits ACC_LAT edges and returns Y/carry.
module acc_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ACC_LAT = 1
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_mode,
  input  logic [3:0]             cmd_a,
  input  logic [3:0]             cmd_b,
  input  logic                   cmd_cin,
  input  logic                   cmd_clr,
  output logic [3:0]             alu_mode,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  output logic                   alu_clr_n,
  input  logic [3:0]             alu_y,
  input  logic                   alu_carry,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [3:0]             rsp_y,
  output logic                   rsp_carry,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_RESP} state_t;

  // op packs {mode, a, b, cin} in the same order as the accumulator port group
  typedef struct packed {
    logic        clr;
    logic [12:0] op;
  } cmd_t;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  state_t        r_state;
  logic [12:0]   r_hold;
  logic [1:0]    r_cnt;
  logic [3:0]    r_alu_mode;
  logic [3:0]    r_alu_a;
  logic [3:0]    r_alu_b;
  logic          r_alu_cin;
  logic          r_alu_clr_n;
  logic          r_rsp_valid;
  logic [3:0]    r_rsp_y;
  logic          r_rsp_carry;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  cmd_t          w_head;
  cmd_t          w_cmd;

  assign w_empty   = (r_level == '0);
  assign cmd_ready = (r_level != LW'(DEPTH));
  assign w_push    = cmd_valid && cmd_ready;
  // Pop from IDLE, or straight out of RESP on the handshake edge for back-to-back ops
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || (r_state == S_RESP && rsp_ready));
  assign w_head    = r_mem[r_rptr];
  assign w_cmd     = '{clr: cmd_clr, op: {cmd_mode, cmd_a, cmd_b, cmd_cin}};

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wptr] <= w_cmd;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_alu_mode  <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_cin   <= 1'b0;
      r_alu_clr_n <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_carry <= 1'b0;
    end else begin
      r_alu_clr_n <= 1'b1;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (r_state == S_RESP && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
          if (w_pop) begin
            r_hold <= w_head.op;
            if (w_head.clr) begin
              r_alu_clr_n <= 1'b0;
              r_state     <= S_CLEAR;
            end else begin
              {r_alu_mode, r_alu_a, r_alu_b, r_alu_cin} <= w_head.op;
              r_state <= S_ISSUE;
            end
          end
        end
        S_CLEAR: begin
          {r_alu_mode, r_alu_a, r_alu_b, r_alu_cin} <= r_hold;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_cnt   <= 2'(ACC_LAT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_y     <= alu_y;
            r_rsp_carry <= alu_carry;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_mode  = r_alu_mode;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_cin   = r_alu_cin;
  assign alu_clr_n = r_alu_clr_n;
  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;
  assign rsp_carry = r_rsp_carry;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign level     = r_level;

endmodule

// File: tb/tb_acc_op_sequencer.sv
// Directed bench for acc_op_sequencer: ACC_LAT=1 and ACC_LAT=3 instances, each driving a
// behavioural accumulator that applies each newly issued op once.
module tb_acc_op_sequencer;

  logic Clk = 1'b0;
  logic nReset;
  always #5 Clk = ~Clk;

  logic       cmd_valid, cmd_ready, cmd_cin, cmd_clr;
  logic [3:0] cmd_mode, cmd_a, cmd_b;
  logic [3:0] alu_mode, alu_a, alu_b, alu_y;
  logic       alu_cin, alu_clr_n, alu_carry;
  logic       rsp_valid, rsp_ready, rsp_carry, busy;
  logic [3:0] rsp_y;
  logic [2:0] level;

  logic       c3_valid, c3_ready, c3_cin, c3_clr;
  logic [3:0] c3_mode, c3_a, c3_b;
  logic [3:0] a3_mode, a3_a, a3_b, a3_y;
  logic       a3_cin, a3_clr_n, a3_carry;
  logic       r3_valid, r3_ready, r3_carry, busy3;
  logic [3:0] r3_y;
  logic [2:0] level3;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] exp_y [8];
  logic       exp_c [8];

  acc_op_sequencer #(.DEPTH(4), .ACC_LAT(1)) u_dut (
    .Clk(Clk), .nReset(nReset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_clr(cmd_clr),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_clr_n(alu_clr_n),
    .alu_y(alu_y), .alu_carry(alu_carry), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_carry(rsp_carry), .busy(busy), .level(level));

  acc_op_sequencer #(.DEPTH(4), .ACC_LAT(3)) u_dut3 (
    .Clk(Clk), .nReset(nReset), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_mode(c3_mode), .cmd_a(c3_a), .cmd_b(c3_b), .cmd_cin(c3_cin), .cmd_clr(c3_clr),
    .alu_mode(a3_mode), .alu_a(a3_a), .alu_b(a3_b), .alu_cin(a3_cin), .alu_clr_n(a3_clr_n),
    .alu_y(a3_y), .alu_carry(a3_carry), .rsp_valid(r3_valid), .rsp_ready(r3_ready),
    .rsp_y(r3_y), .rsp_carry(r3_carry), .busy(busy3), .level(level3));

  function automatic logic [4:0] acc_op(input logic [3:0] acc, input logic [3:0] mode,
                                        input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
    case (mode)
      4'd0:    return {1'b0, acc} + {1'b0, a} + {1'b0, b} + {4'd0, cin};
      4'd1:    return {1'b0, acc} - {1'b0, b};
      default: return {1'b0, acc};
    endcase
  endfunction

  // Accumulator stubs: an op is applied once, on the first edge that sees new port values
  logic [12:0] last1, last3;
  logic        lv1, lv3;
  always_ff @(posedge Clk or negedge alu_clr_n) begin
    if (!alu_clr_n) begin
      alu_y <= '0; alu_carry <= 1'b0; lv1 <= 1'b0; last1 <= '0;
    end else if (!lv1 || last1 != {alu_mode, alu_a, alu_b, alu_cin}) begin
      lv1   <= 1'b1;
      last1 <= {alu_mode, alu_a, alu_b, alu_cin};
      {alu_carry, alu_y} <= acc_op(alu_y, alu_mode, alu_a, alu_b, alu_cin);
    end
  end
  always_ff @(posedge Clk or negedge a3_clr_n) begin
    if (!a3_clr_n) begin
      a3_y <= '0; a3_carry <= 1'b0; lv3 <= 1'b0; last3 <= '0;
    end else if (!lv3 || last3 != {a3_mode, a3_a, a3_b, a3_cin}) begin
      lv3   <= 1'b1;
      last3 <= {a3_mode, a3_a, a3_b, a3_cin};
      {a3_carry, a3_y} <= acc_op(a3_y, a3_mode, a3_a, a3_b, a3_cin);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic clr, input logic [3:0] mode, input logic [3:0] a,
                      input logic [3:0] b, input logic cin);
    cmd_clr = clr; cmd_mode = mode; cmd_a = a; cmd_b = b; cmd_cin = cin;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Expects n responses (rsp_ready held high) matching exp_y/exp_c in order
  task automatic collect(input string tag, input int n);
    int idx = 0;
    for (int cyc = 0; cyc < 60 && idx < n; cyc++) begin
      if (rsp_valid) begin
        chk({tag, "_y"}, 8'(rsp_y), 8'(exp_y[idx]));
        chk({tag, "_c"}, 8'(rsp_carry), 8'(exp_c[idx]));
        idx++;
      end
      if (idx < n) tick();
    end
    chk({tag, "_count"}, 8'(idx), 8'(n));
  endtask

  initial begin
    int lat;
    logic [4:0] s;
    logic [3:0] macc;
    int sz [4] = '{3, 3, 2, 2};
    int i;

    nReset = 1'b1;
    cmd_valid = 0; cmd_clr = 0; cmd_mode = 0; cmd_a = 0; cmd_b = 0; cmd_cin = 0;
    rsp_ready = 1'b1;
    c3_valid = 0; c3_clr = 0; c3_mode = 0; c3_a = 0; c3_b = 0; c3_cin = 0;
    c3_ready = 1'b1;
    #2 nReset = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_level", 8'(level), 8'd0);
    chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    chk("rst_clr_n", 8'(alu_clr_n), 8'd0);
    chk("rst_alu", 8'({alu_mode, alu_a, alu_b, alu_cin}), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_ready", 8'(cmd_ready), 8'd1);
    nReset = 1'b1;
    tick();
    chk("clr_n_release", 8'(alu_clr_n), 8'd1);

    // Single op with clear: 2+1 from cleared acc
    push(1, 4'd0, 4'd2, 4'd1, 0);
    chk("t1_level_push", 8'(level), 8'd1);
    tick();
    chk("t1_clr_low", 8'(alu_clr_n), 8'd0);
    chk("t1_level_pop", 8'(level), 8'd0);
    tick();
    chk("t1_clr_high", 8'(alu_clr_n), 8'd1);
    chk("t1_issue_ab", 8'({alu_a, alu_b}), 8'h21);
    tick();
    chk("t1_not_yet", 8'(rsp_valid), 8'd0);
    tick();
    chk("t1_valid", 8'(rsp_valid), 8'd1);
    chk("t1_y", 8'(rsp_y), 8'd3);
    chk("t1_c", 8'(rsp_carry), 8'd0);
    tick();
    chk("t1_valid_drop", 8'(rsp_valid), 8'd0);
    chk("t1_busy", 8'(busy), 8'd0);

    // Back-to-back pushes with response stalled until the FIFO fills
    rsp_ready = 1'b0;
    push(1, 4'd0, 4'd5, 4'd5, 0);
    push(0, 4'd0, 4'd3, 4'd9, 0);
    push(0, 4'd1, 4'd0, 4'd2, 0);
    push(0, 4'd0, 4'd1, 4'd0, 0);
    push(0, 4'd0, 4'd2, 4'd0, 0);
    chk("fill_level", 8'(level), 8'd4);
    chk("fill_ready", 8'(cmd_ready), 8'd0);
    chk("first_rsp_valid", 8'(rsp_valid), 8'd1);
    push(0, 4'd0, 4'd15, 4'd15, 0);
    chk("full_push_ignored", 8'(level), 8'd4);
    for (int k = 0; k < 6; k++) begin
      chk("stall_valid", 8'(rsp_valid), 8'd1);
      chk("stall_y", 8'(rsp_y), 8'd10);
      chk("stall_c", 8'(rsp_carry), 8'd0);
      chk("stall_no_issue", 8'({alu_a, alu_b}), 8'h55);
      chk("stall_level", 8'(level), 8'd4);
      tick();
    end
    exp_y[0] = 4'd10; exp_c[0] = 0;
    exp_y[1] = 4'd6;  exp_c[1] = 1;
    exp_y[2] = 4'd4;  exp_c[2] = 0;
    exp_y[3] = 4'd5;  exp_c[3] = 0;
    exp_y[4] = 4'd7;  exp_c[4] = 0;
    rsp_ready = 1'b1;
    collect("drain", 5);
    tick();
    chk("drain_level", 8'(level), 8'd0);
    chk("drain_busy", 8'(busy), 8'd0);
    chk("drain_ready", 8'(cmd_ready), 8'd1);

    // Reset while in WAIT with three entries queued
    rsp_ready = 1'b0;
    push(0, 4'd0, 4'd1, 4'd1, 0);
    push(0, 4'd0, 4'd2, 4'd2, 0);
    push(0, 4'd0, 4'd3, 4'd3, 0);
    push(0, 4'd0, 4'd4, 4'd4, 0);
    rsp_ready = 1'b1;
    push(0, 4'd0, 4'd5, 4'd6, 0);
    rsp_ready = 1'b0;
    tick();
    chk("pre_rst_level", 8'(level), 8'd3);
    chk("pre_rst_valid", 8'(rsp_valid), 8'd0);
    chk("pre_rst_alu_a", 8'(alu_a), 8'd2);
    nReset = 1'b0;
    #1;
    chk("mid_rst_level", 8'(level), 8'd0);
    chk("mid_rst_valid", 8'(rsp_valid), 8'd0);
    chk("mid_rst_clr_n", 8'(alu_clr_n), 8'd0);
    chk("mid_rst_alu", 8'({alu_mode, alu_a, alu_b, alu_cin}), 8'd0);
    tick();
    nReset = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_quiet", 8'(rsp_valid), 8'd0);
      chk("post_rst_level", 8'(level), 8'd0);
    end
    chk("post_rst_busy", 8'(busy), 8'd0);

    // ACC_LAT=1 latency without clear: rsp_valid after the third edge following the push
    push(0, 4'd0, 4'd4, 4'd4, 0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    chk("lat1", 8'(lat), 8'd3);
    chk("lat1_y", 8'(rsp_y), 8'd8);

    // Pointer wrap: ten ops in groups, checked against a running model
    macc = 4'd8;
    i = 0;
    tick();
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < sz[g]; k++) begin
        push(0, 4'd0, 4'(i), 4'd1, 0);
        s = {1'b0, macc} + 5'(i) + 5'd1;
        macc = s[3:0];
        exp_y[k] = s[3:0];
        exp_c[k] = s[4];
        i++;
      end
      if (sz[g] == 3) chk("wrap_level_peak", 8'(level), 8'd2);
      collect("wrap", sz[g]);
    end
    tick();
    chk("wrap_level_end", 8'(level), 8'd0);
    chk("wrap_busy_end", 8'(busy), 8'd0);

    // ACC_LAT=3: two edges later than the ACC_LAT=1 case
    c3_mode = 4'd0; c3_a = 4'd7; c3_b = 4'd2; c3_cin = 0; c3_clr = 0;
    c3_valid = 1'b1;
    tick();
    c3_valid = 1'b0;
    lat = 0;
    while (!r3_valid && lat < 20) begin tick(); lat++; end
    chk("lat3", 8'(lat), 8'd5);
    chk("lat3_y", 8'(r3_y), 8'd9);
    chk("lat3_c", 8'(r3_carry), 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
